// File: rtl/scsa_carry_corrector.sv
// Sequential exact-sum corrector for the speculative carry-select adder: ripples one
// BLK_W block per cycle and scores the speculation. Define SCSA_ERR_MASK_EN for err_mask.
module scsa_blk_step #(
  parameter int BLK_W = 4
) (
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic [BLK_W-1:0] approx,
  input  logic             cin,
  output logic [BLK_W-1:0] s,
  output logic             cout,
  output logic             miss
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{BLK_W{1'b0}}, cin};
  assign miss      = (s != approx);
endmodule

module scsa_carry_corrector #(
  parameter int NBLK  = 8,
  parameter int BLK_W = 4,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NBLK*BLK_W-1:0] op_a,
  input  logic [NBLK*BLK_W-1:0] op_b,
  input  logic [NBLK*BLK_W-1:0] approx_sum,
  input  logic                  approx_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBLK*BLK_W-1:0] exact_sum,
  output logic                  exact_cout,
  output logic                  err_flag,
  output logic [CNT_W-1:0]      err_cnt
`ifdef SCSA_ERR_MASK_EN
  ,
  output logic [NBLK-1:0]       err_mask
`endif
);
  localparam int N     = NBLK * BLK_W;
  localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d, ap_q, ap_d;
  logic               apc_q, apc_d;
  logic [N-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               err_flag_q, err_flag_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               out_valid_q, out_valid_d;
`ifdef SCSA_ERR_MASK_EN
  logic [NBLK-1:0]    mask_q, mask_d;
`endif

  logic [BLK_W-1:0]   blk_a, blk_b, blk_ap, blk_s;
  logic               blk_c, blk_miss;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_blk;

  // Captured operands are sliced by the running block index; inputs are never
  // looked at again after acceptance.
  assign blk_a  = a_q[int'(idx_q)*BLK_W +: BLK_W];
  assign blk_b  = b_q[int'(idx_q)*BLK_W +: BLK_W];
  assign blk_ap = ap_q[int'(idx_q)*BLK_W +: BLK_W];

  scsa_blk_step #(.BLK_W(BLK_W)) u_step (
    .a      (blk_a),
    .b      (blk_b),
    .approx (blk_ap),
    .cin    (carry_q),
    .s      (blk_s),
    .cout   (blk_c),
    .miss   (blk_miss)
  );

  assign cnt_inc  = err_cnt_q + CNT_W'(blk_miss);
  assign last_blk = (idx_q == IDX_W'(NBLK-1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    ap_d        = ap_q;
    apc_d       = apc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    out_valid_d = out_valid_q;
`ifdef SCSA_ERR_MASK_EN
    mask_d      = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = op_a;
          b_d       = op_b;
          ap_d      = approx_sum;
          apc_d     = approx_cout;
          carry_d   = 1'b0;
          idx_d     = '0;
          err_cnt_d = '0;
          sum_d     = '0;
`ifdef SCSA_ERR_MASK_EN
          mask_d    = '0;
`endif
          state_d   = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*BLK_W +: BLK_W] = blk_s;
        carry_d   = blk_c;
        err_cnt_d = cnt_inc;
`ifdef SCSA_ERR_MASK_EN
        mask_d[idx_q] = blk_miss;
`endif
        if (last_blk) begin
          cout_d      = blk_c;
          err_flag_d  = (cnt_inc != '0) || (blk_c != apc_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ap_q        <= '0;
      apc_q       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef SCSA_ERR_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ap_q        <= ap_d;
      apc_q       <= apc_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
`ifdef SCSA_ERR_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign exact_sum  = sum_q;
  assign exact_cout = cout_q;
  assign err_flag   = err_flag_q;
  assign err_cnt    = err_cnt_q;
`ifdef SCSA_ERR_MASK_EN
  assign err_mask   = mask_q;
`endif
endmodule

// File: tb/tb_scsa_carry_corrector.sv
// Randomized and directed bench for scsa_carry_corrector against an arithmetic
// reference model of the exact sum and per-block mis-speculation score.
module tb_scsa_carry_corrector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0, op_b = '0, approx_sum = '0;
  logic        approx_cout = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] exact_sum;
  logic        exact_cout, err_flag;
  logic [3:0]  err_cnt;
`ifdef SCSA_ERR_MASK_EN
  logic [7:0]  err_mask;
`endif

  int total = 0;
  int bad   = 0;

  scsa_carry_corrector #(.NBLK(8), .BLK_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .approx_sum(approx_sum), .approx_cout(approx_cout),
    .out_valid(out_valid), .out_ready(out_ready), .exact_sum(exact_sum),
    .exact_cout(exact_cout), .err_flag(err_flag), .err_cnt(err_cnt)
`ifdef SCSA_ERR_MASK_EN
    , .err_mask(err_mask)
`endif
  );

  always #5 clk = ~clk;

  // Reference: true 33-bit sum, then score each nibble against the speculation.
  function automatic logic [45:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] ap, input logic apc);
    logic [32:0] full;
    logic [3:0]  cnt;
    logic [7:0]  m;
    logic        f;
    full = {1'b0, a} + {1'b0, b};
    cnt = 0; m = 0;
    for (int i = 0; i < 8; i++)
      if (full[i*4 +: 4] != ap[i*4 +: 4]) begin cnt++; m[i] = 1'b1; end
    f = (cnt != 0) || (full[32] != apc);
    return {m, full[31:0], full[32], f, cnt};
  endfunction

  function automatic logic [37:0] observed();
    return {exact_sum, exact_cout, err_flag, err_cnt};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ap, input logic apc);
    @(negedge clk);
    op_a = a; op_b = b; approx_sum = ap; approx_cout = apc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ap, input logic apc);
    logic [45:0] exp;
    int cyc;
    exp = model(a, b, ap, apc);
    send(a, b, ap, apc);
    wait_done(cyc);
    total++;
    if (cyc !== 8) begin bad++; $display("FAIL %s latency got=%0d want=8", name, cyc); end
    total++;
    if (observed() !== exp[37:0]) begin
      bad++; $display("FAIL %s result got=%h want=%h", name, observed(), exp[37:0]);
    end
`ifdef SCSA_ERR_MASK_EN
    total++;
    if (err_mask !== exp[45:38]) begin
      bad++; $display("FAIL %s mask got=%h want=%h", name, err_mask, exp[45:38]);
    end
`endif
    handshake();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({out_valid, observed()} !== 39'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {out_valid, observed()});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_exact();
    directed("exact", 32'h1, 32'h1, 32'h2, 1'b0);
  endtask

  task automatic test_single_miss();
    directed("single_miss", 32'hF, 32'h1, 32'h0, 1'b0);
  endtask

  task automatic test_long_propagate();
    directed("long_prop", 32'hFFFFFFFF, 32'h1, 32'hFFFFFF00, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [37:0] held;
    logic [45:0] exp;
    int cyc;
    exp = model(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678, 1'b1);
    send(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678, 1'b1);
    wait_done(cyc);
    held = observed();
    total++;
    if (held !== exp[37:0]) begin bad++; $display("FAIL bp_result got=%h want=%h", held, exp[37:0]); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, exp[37:0]}) begin
        bad++; $display("FAIL bp_stall%0d got=%b%b_%h want=10_%h", i, out_valid, in_ready,
                        observed(), exp[37:0]);
      end
    end
    handshake();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_release got=%b want=01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    total++;
    if (observed() !== exp[37:0]) begin
      bad++; $display("FAIL bp_idle_hold got=%h want=%h", observed(), exp[37:0]);
    end
    directed("b2b", 32'h12345678, 32'h11111111, 32'h23456789, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    total++;
    if ({out_valid, observed()} !== 39'd0) begin
      bad++; $display("FAIL midrun_reset got=%h want=0", {out_valid, observed()});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL midrun_release got=%b want=10", {in_ready, out_valid});
    end
    directed("after_reset", 32'h0000FFFF, 32'h00000001, 32'h00000000, 1'b0);
  endtask

  task automatic test_isolation();
    logic [45:0] exp;
    int cyc;
    exp = model(32'h01234567, 32'h89ABCDEF, 32'h8ACF1356, 1'b0);
    send(32'h01234567, 32'h89ABCDEF, 32'h8ACF1356, 1'b0);
    op_a = 32'hDEADBEEF; op_b = 32'h0; approx_sum = 32'h0; approx_cout = 1'b1;
    @(negedge clk); in_valid = 1'b1;
    wait_done(cyc);
    in_valid = 1'b0;
    total++;
    if (observed() !== exp[37:0]) begin
      bad++; $display("FAIL isolation got=%h want=%h", observed(), exp[37:0]);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [31:0] a, b, ap, flip;
    logic        apc;
    logic [45:0] exp;
    int cyc;
    for (int n = 0; n < 30; n++) begin
      a = $urandom; b = $urandom;
      flip = 0;
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 3) == 0) flip[i*4 +: 4] = 4'($urandom_range(1, 15));
      ap  = (a + b) ^ flip;
      apc = 1'($urandom_range(0, 1));
      exp = model(a, b, ap, apc);
      send(a, b, ap, apc);
      wait_done(cyc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      total++;
      if ({cyc == 8, observed()} !== {1'b1, exp[37:0]}) begin
        bad++; $display("FAIL rand%0d cyc=%0d got=%h want=%h", n, cyc, observed(), exp[37:0]);
      end
`ifdef SCSA_ERR_MASK_EN
      total++;
      if (err_mask !== exp[45:38]) begin
        bad++; $display("FAIL rand%0d_mask got=%h want=%h", n, err_mask, exp[45:38]);
      end
`endif
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_single_miss();
    test_long_propagate();
    test_backpressure();
    test_reset_mid_run();
    test_isolation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
